jtcontra_snd_cmd: RTL and testbench



---
 rtl/jtcontra_snd_cmd.sv | 162 ++++++++++++++++
 tb/tb_jtcontra_snd_cmd.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_snd_cmd.sv
// Main-CPU side of the sound-command link: queues CPU writes in a small FIFO and
// presents them one at a time on snd_latch, each announced by an snd_irq pulse.
module jtcontra_snd_cmd #(
  parameter int unsigned AW      = 2,
  parameter int unsigned IRQ_LEN = 8,
  parameter int unsigned TOUT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       st_cs,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       snd_ack,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       busy
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned IW    = $clog2(IRQ_LEN);
  localparam int unsigned CW    = (TOUT_W > IW) ? TOUT_W : IW;
  localparam logic [CW-1:0] IrqLast = CW'(IRQ_LEN - 1);
  localparam logic [AW:0]   FullCnt = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StIrq, StWait} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          ack_seen_q, ack_seen_d;
  logic          irq_q, irq_d;
  logic [7:0]    latch_q, latch_d;
  logic          oflow_q, oflow_d;
  logic          tout_q, tout_d, tout_set;

  logic          wr_lvl, wr_q, wr_ev_q;
  logic          rd_lvl, rd_q, rd_ev_q;
  logic          ack_q, ack_ev_q;

  logic [7:0]    mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;

  assign wr_lvl = cs & ~wr_n;
  assign rd_lvl = st_cs & ~rd_n;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  assign pop   = (state_q == StIdle) & ~empty;
  // A slot freed by this cycle's pop makes room for a push while full.
  assign push  = wr_ev_q & (~full | pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_seen_d = ack_seen_q;
    irq_d      = irq_q;
    latch_d    = latch_q;
    tout_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          latch_d = mem_q[rd_ptr_q];
          state_d = StLoad;
        end
      end
      StLoad: begin
        irq_d      = 1'b1;
        cnt_d      = '0;
        ack_seen_d = 1'b0;
        state_d    = StIrq;
      end
      StIrq: begin
        if (ack_ev_q) ack_seen_d = 1'b1;
        if (cnt_q == IrqLast) begin
          irq_d   = 1'b0;
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWait: begin
        if (ack_ev_q || ack_seen_q) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (&cnt_inc[TOUT_W-1:0]) begin
            tout_set = 1'b1;
            state_d  = StIdle;
          end
        end
      end
    endcase
  end

  // Sticky flags: a set on the same cycle as the read-clear wins.
  assign oflow_d = (oflow_q & ~rd_ev_q) | (wr_ev_q & full & ~pop);
  assign tout_d  = (tout_q & ~rd_ev_q) | tout_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ack_seen_q <= 1'b0;
      irq_q      <= 1'b0;
      latch_q    <= 8'd0;
      oflow_q    <= 1'b0;
      tout_q     <= 1'b0;
      wr_q       <= 1'b0;
      wr_ev_q    <= 1'b0;
      rd_q       <= 1'b0;
      rd_ev_q    <= 1'b0;
      ack_q      <= 1'b0;
      ack_ev_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_seen_q <= ack_seen_d;
      irq_q      <= irq_d;
      latch_q    <= latch_d;
      oflow_q    <= oflow_d;
      tout_q     <= tout_d;
      wr_q       <= wr_lvl;
      wr_ev_q    <= wr_lvl & ~wr_q;
      rd_q       <= rd_lvl;
      rd_ev_q    <= ~rd_lvl & rd_q;
      ack_q      <= snd_ack;
      ack_ev_q   <= snd_ack & ~ack_q;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign busy      = (state_q != StIdle) | ~empty;
  assign dout      = {oflow_q, tout_q, 3'd0, empty, busy, full};
  assign snd_latch = latch_q;
  assign snd_irq   = irq_q;

endmodule

// File: tb/tb_jtcontra_snd_cmd.sv
// Directed bench for jtcontra_snd_cmd: reset, single command, burst/overflow,
// timeout, early ack and push-while-full-and-popping.
module tb_jtcontra_snd_cmd;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs, st_cs, wr_n, rd_n, snd_ack;
  logic [7:0] din;
  logic [7:0] dout, snd_latch;
  logic       snd_irq, busy;

  int checks = 0;
  int errors = 0;

  jtcontra_snd_cmd #(
    .AW      (2),
    .IRQ_LEN (8),
    .TOUT_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .st_cs     (st_cs),
    .wr_n      (wr_n),
    .rd_n      (rd_n),
    .din       (din),
    .dout      (dout),
    .snd_ack   (snd_ack),
    .snd_latch (snd_latch),
    .snd_irq   (snd_irq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] d);
    din  = d;
    cs   = 1'b1;
    wr_n = 1'b0;
    step();
    cs   = 1'b0;
    wr_n = 1'b1;
    step();
  endtask

  task automatic cpu_rd(output logic [7:0] d);
    st_cs = 1'b1;
    rd_n  = 1'b0;
    d     = dout;
    step();
    st_cs = 1'b0;
    rd_n  = 1'b1;
    step();
    step();
  endtask

  task automatic ack_pulse();
    snd_ack = 1'b1;
    step();
    snd_ack = 1'b0;
    step();
  endtask

  // Wait (bounded) for the next IRQ rise, check the latch, then ack in WAIT.
  task automatic serve(input logic [7:0] exp, input int dly);
    int n = 0;
    while (snd_irq !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check("irq_seen", {7'd0, snd_irq}, 8'h01);
    check("cmd_order", snd_latch, exp);
    repeat (dly) step();
    ack_pulse();
  endtask

  initial begin
    logic [7:0] rd;
    logic       seen;
    int         n;
    cs = 1'b0; st_cs = 1'b0; wr_n = 1'b1; rd_n = 1'b1; din = 8'd0; snd_ack = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 8'h04);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_latch", snd_latch, 8'h00);
    check("rst_irq", {7'd0, snd_irq}, 8'h00);
    rst = 1'b0;
    step();

    // Reset in the middle of an IRQ pulse with three commands queued
    cpu_wr(8'hA1);
    cpu_wr(8'hA2);
    cpu_wr(8'hA3);
    cpu_wr(8'hA4);
    check("pre_rst_irq", {7'd0, snd_irq}, 8'h01);
    check("pre_rst_dout", dout, 8'h02);
    #2 rst = 1'b1;
    #1;
    check("async_irq_low", {7'd0, snd_irq}, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("rel_dout", dout, 8'h04);
    check("rel_busy", {7'd0, busy}, 8'h00);
    check("rel_latch", snd_latch, 8'h00);

    // Single command, ack 20 clks after the IRQ rise
    din = 8'h5A; cs = 1'b1; wr_n = 1'b0;
    step();
    check("empty_before_push", dout, 8'h04);
    cs = 1'b0; wr_n = 1'b1;
    step();
    check("empty_after_push", dout, 8'h02);
    step();
    check("latch_before_irq", snd_latch, 8'h5A);
    check("irq_low_in_load", {7'd0, snd_irq}, 8'h00);
    step();
    check("irq_rise", {7'd0, snd_irq}, 8'h01);
    repeat (7) step();
    check("irq_8th_clk", {7'd0, snd_irq}, 8'h01);
    step();
    check("irq_fall", {7'd0, snd_irq}, 8'h00);
    repeat (12) step();
    snd_ack = 1'b1;
    step();
    check("busy_ack_plus1", {7'd0, busy}, 8'h01);
    snd_ack = 1'b0;
    step();
    check("busy_ack_plus2", {7'd0, busy}, 8'h00);
    check("single_done_dout", dout, 8'h04);

    // Burst: one in flight, four queued, fifth dropped
    cpu_wr(8'h99);
    cpu_wr(8'h11);
    cpu_wr(8'h22);
    cpu_wr(8'h33);
    cpu_wr(8'h44);
    check("burst_full", dout, 8'h03);
    cpu_wr(8'h55);
    check("oflow_set", dout, 8'h83);
    cpu_rd(rd);
    check("rd1_oflow", rd, 8'h83);
    cpu_rd(rd);
    check("rd2_cleared", rd, 8'h03);
    ack_pulse();
    check("burst_no_tout", dout, 8'h03);
    serve(8'h11, 10);
    serve(8'h22, 10);
    serve(8'h33, 10);
    serve(8'h44, 10);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen = seen | snd_irq;
    end
    check("no_55_sent", {7'd0, seen}, 8'h00);
    check("burst_idle", dout, 8'h04);

    // Timeout: no ack, WAIT lasts 15 clks, then the next command goes out
    cpu_wr(8'h66);
    cpu_wr(8'h77);
    repeat (22) step();
    check("wait_14", dout, 8'h02);
    step();
    check("tout_set", dout, 8'h42);
    step();
    check("next_latch", snd_latch, 8'h77);
    check("next_irq_low", {7'd0, snd_irq}, 8'h00);
    step();
    check("next_irq_rise", {7'd0, snd_irq}, 8'h01);

    // Early ack during IRQ: single WAIT clk, tout stays clear
    cpu_rd(rd);
    check("rd_tout", rd, 8'h46);
    check("tout_cleared", dout, 8'h06);
    check("still_in_irq", {7'd0, snd_irq}, 8'h01);
    ack_pulse();
    n = 0;
    while (snd_irq === 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("early_irq_fell", {7'd0, snd_irq}, 8'h00);
    check("early_wait_busy", {7'd0, busy}, 8'h01);
    step();
    check("early_wait_1clk", {7'd0, busy}, 8'h00);
    repeat (20) step();
    check("early_no_tout", dout, 8'h04);

    // Push on full coinciding with the IDLE pop
    cpu_wr(8'hB0);
    cpu_wr(8'hB1);
    cpu_wr(8'hB2);
    cpu_wr(8'hB3);
    cpu_wr(8'hB4);
    check("sim_full", dout, 8'h03);
    step();
    step();
    check("sim_in_wait", {7'd0, snd_irq}, 8'h00);
    snd_ack = 1'b1;
    step();
    snd_ack = 1'b0;
    din = 8'hB5; cs = 1'b1; wr_n = 1'b0;
    step();
    cs = 1'b0; wr_n = 1'b1;
    step();
    check("sim_full_kept", dout, 8'h03);
    serve(8'hB1, 10);
    serve(8'hB2, 10);
    serve(8'hB3, 10);
    serve(8'hB4, 10);
    serve(8'hB5, 10);
    check("sim_done", dout, 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
